// File: rtl/bg5_read_logic_if.sv
// bg5_read_logic_if: burst request, per-bank SRAM port and beat-stream signals of bg5_read_logic.
interface bg5_read_logic_if;
  logic start, bg_sel;
  logic [7:0] base_addr;
  logic [8:0] len;
  logic [55:0] addr_out;
  logic [7:0] ce_out, wen_out;
  logic [255:0] din0, din1, din2, din3, din4, din5, din6, din7;
  logic [511:0] dout;
  logic dout_valid, dout_ready, busy, done;
  logic [15:0] stall_cnt;
  modport slave (
    input start, bg_sel, base_addr, len, din0, din1, din2, din3, din4, din5, din6, din7, dout_ready,
    output addr_out, ce_out, wen_out, dout, dout_valid, busy, done, stall_cnt
  );
  modport master (
    output start, bg_sel, base_addr, len, din0, din1, din2, din3, din4, din5, din6, din7, dout_ready,
    input addr_out, ce_out, wen_out, dout, dout_valid, busy, done, stall_cnt
  );
endinterface

// File: rtl/bg5_read_logic.sv
// bg5_read_logic: bank-group burst reader pairing two 256-bit SRAM banks per 512-bit beat.
// Optional back-pressure counter enabled by BG5_READ_STALL_CNT_EN.
module bg5_read_logic (
  input logic clk,
  input logic rst,
  bg5_read_logic_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state_q;
  logic busy_q, done_q, bg_q;
  logic [7:0] addr_q;
  logic [8:0] rem_q;
  logic [511:0] mem_q [2];
  logic [511:0] mem_d [2];
  logic wr_q, wr_d, rd_q, rd_d, p1_q, p1_d;
  logic [1:0] cnt_q, cnt_d, pair_q, pair_d, pair;
  logic [255:0] din [8];
  logic [2:0] occ_after;
  logic valid, pop, issue, last_pop;
  logic [7:0] ce;
  logic [55:0] a_out;
  assign din[0] = bus.din0;
  assign din[1] = bus.din1;
  assign din[2] = bus.din2;
  assign din[3] = bus.din3;
  assign din[4] = bus.din4;
  assign din[5] = bus.din5;
  assign din[6] = bus.din6;
  assign din[7] = bus.din7;
  assign valid = cnt_q != 2'd0;
  assign pop = valid && bus.dout_ready;
  // Counting this cycle's pop lets the pipeline sustain one beat per cycle with only two FIFO slots.
  assign occ_after = {1'b0, cnt_q} + {2'b0, p1_q} - {2'b0, pop};
  assign issue = state_q == RUN && occ_after < 3'd2;
  assign last_pop = pop && ({1'b0, cnt_q} + {2'b0, p1_q}) == 3'd1;
  assign pair = {~addr_q[7], bg_q};
  always_comb begin
    ce = '0;
    a_out = '0;
    for (int k = 0; k < 8; k++)
      if (issue && k[1:0] == pair) begin
        ce[k] = 1'b1;
        a_out[7*k+:7] = addr_q[6:0];
      end
  end
  always_comb begin
    mem_d = mem_q;
    if (p1_q) mem_d[wr_q] = {din[{1'b0, pair_q}], din[{1'b1, pair_q}]};
    wr_d = wr_q ^ p1_q;
    rd_d = rd_q ^ pop;
    cnt_d = cnt_q + {1'b0, p1_q} - {1'b0, pop};
    p1_d = issue;
    pair_d = issue ? pair : pair_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      mem_q <= '{default: '0};
      wr_q <= 1'b0;
      rd_q <= 1'b0;
      cnt_q <= 2'd0;
      p1_q <= 1'b0;
      pair_q <= 2'd0;
    end else begin
      mem_q <= mem_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
      p1_q <= p1_d;
      pair_q <= pair_d;
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      bg_q <= 1'b0;
      addr_q <= 8'd0;
      rem_q <= 9'd0;
    end else
      case (state_q)
        IDLE:
          if (bus.start) begin
            bg_q <= bus.bg_sel;
            addr_q <= bus.base_addr;
            rem_q <= bus.len;
            state_q <= bus.len == 9'd0 ? DONE : RUN;
            busy_q <= bus.len != 9'd0;
            done_q <= bus.len == 9'd0;
          end
        RUN:
          if (issue) begin
            addr_q <= addr_q + 8'd1;
            rem_q <= rem_q - 9'd1;
            if (rem_q == 9'd1) state_q <= DRAIN;
          end
        DRAIN:
          if (last_pop) begin
            state_q <= DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end
        default: begin
          state_q <= IDLE;
          done_q <= 1'b0;
        end
      endcase
`ifdef BG5_READ_STALL_CNT_EN
  logic [15:0] stall_q, stall_d;
  always_comb
    stall_d = (state_q == IDLE && bus.start) ? 16'd0 :
              (busy_q && valid && !bus.dout_ready && stall_q != 16'hFFFF) ? stall_q + 16'd1 : stall_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) stall_q <= 16'd0;
    else stall_q <= stall_d;
  assign bus.stall_cnt = stall_q;
`else
  assign bus.stall_cnt = 16'd0;
`endif
  assign bus.ce_out = ce;
  assign bus.addr_out = a_out;
  assign bus.wen_out = 8'd0;
  assign bus.dout = mem_q[rd_q];
  assign bus.dout_valid = valid;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
endmodule
